// File: rtl/ask4_slicer_mer.sv
// 4-ASK symbol slicer with block-averaged reference level and error-power (MER) estimation.
// Sits after the final decimating halfband; the reference estimate feeds back into the thresholds.
module ask4_slicer_mer #(
    parameter int unsigned LOG2_N    = 10,
    parameter int unsigned SKIP_SYMS = 32,
    parameter int signed   REF_INIT  = 16384
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sam_clk_en,
    input  logic               sym_clk_en,
    input  logic signed [17:0] x_in,
    input  logic               clear,
    output logic [1:0]         sym_out,
    output logic signed [17:0] dec_level,
    output logic signed [17:0] ref_level,
    output logic [20:0]        err_power,
    output logic               mer_valid
);

    localparam int unsigned ABS_W     = 18 + LOG2_N;
    localparam int unsigned ERR_W     = 21 + LOG2_N;
    localparam int unsigned CNT_W     = (LOG2_N > 0) ? LOG2_N : 1;
    localparam int unsigned CNT_LAST  = (1 << LOG2_N) - 1;
    localparam int unsigned SKIP_W    = (SKIP_SYMS > 1) ? $clog2(SKIP_SYMS) : 1;
    localparam int unsigned SKIP_LAST = (SKIP_SYMS > 0) ? SKIP_SYMS - 1 : 0;

    typedef enum logic {ST_SKIP, ST_ACCUM} state_t;
    localparam state_t ST_START = (SKIP_SYMS == 0) ? ST_ACCUM : ST_SKIP;

    state_t                   r_state;
    logic [SKIP_W-1:0]        r_skip;
    logic [CNT_W-1:0]         r_cnt;
    logic [ABS_W-1:0]         r_abs_acc;
    logic [ERR_W-1:0]         r_err_acc;

    logic signed [18:0]       w_x, w_a, w_2a, w_3a, w_lvl, w_e;
    logic [1:0]               w_sym;
    logic signed [17:0]       w_dec;
    logic signed [37:0]       w_sq;
    logic [20:0]              w_sqs;
    logic [17:0]              w_abs;
    logic [ABS_W-1:0]         w_abs_sum;
    logic [ERR_W-1:0]         w_err_sum;
    logic [17:0]              w_ref_new;
    logic [20:0]              w_err_new;
    logic                     w_unused_sam;

    // Sample-rate enable is reserved; the slicer runs purely at symbol rate.
    assign w_unused_sam = sam_clk_en;

    assign w_x  = 19'(x_in);
    assign w_a  = 19'(ref_level);
    assign w_2a = w_a <<< 1;
    assign w_3a = w_2a + w_a;

    // Decision regions are centred on the ideal levels +-A, +-3A.
    always_comb begin
        w_sym = 2'b00;
        w_lvl = -w_3a;
        if (w_x >= w_2a) begin
            w_sym = 2'b11;
            w_lvl = w_3a;
        end else if (w_x >= 19'sd0) begin
            w_sym = 2'b10;
            w_lvl = w_a;
        end else if (w_x >= -w_2a) begin
            w_sym = 2'b01;
            w_lvl = -w_a;
        end
    end

    always_comb begin
        w_dec = 18'(w_lvl);
        if (w_lvl > 19'sd131071) begin
            w_dec = 18'sd131071;
        end else if (w_lvl < -19'sd131071) begin
            w_dec = -18'sd131071;
        end
    end

    // Error uses the unsaturated level so a large A still yields the true slicer error.
    assign w_e   = w_x - w_lvl;
    assign w_sq  = 38'(w_e) * 38'(w_e);
    assign w_sqs = 21'($unsigned(w_sq) >> 17);
    assign w_abs = (x_in == -18'sd131072) ? 18'd131071 :
                   (x_in[17] ? $unsigned(18'(-x_in)) : $unsigned(x_in));

    assign w_abs_sum = r_abs_acc + ABS_W'(w_abs);
    assign w_err_sum = r_err_acc + ERR_W'(w_sqs);
    assign w_ref_new = 18'(w_abs_sum >> (LOG2_N + 1));
    assign w_err_new = 21'(w_err_sum >> LOG2_N);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_START;
            r_skip    <= '0;
            r_cnt     <= '0;
            r_abs_acc <= '0;
            r_err_acc <= '0;
            sym_out   <= 2'b00;
            dec_level <= 18'sd0;
            ref_level <= 18'(REF_INIT);
            err_power <= '0;
            mer_valid <= 1'b0;
        end else begin
            mer_valid <= 1'b0;
            if (sym_clk_en) begin
                sym_out   <= w_sym;
                dec_level <= w_dec;
            end
            // A clear drops the coincident sample from the measurement but it is still sliced.
            if (clear) begin
                r_state   <= ST_START;
                r_skip    <= '0;
                r_cnt     <= '0;
                r_abs_acc <= '0;
                r_err_acc <= '0;
            end else if (sym_clk_en) begin
                case (r_state)
                    ST_SKIP: begin
                        if (r_skip == SKIP_W'(SKIP_LAST)) begin
                            r_state <= ST_ACCUM;
                            r_skip  <= '0;
                        end else begin
                            r_skip <= r_skip + 1'b1;
                        end
                    end
                    ST_ACCUM: begin
                        if (r_cnt == CNT_W'(CNT_LAST)) begin
                            ref_level <= (w_ref_new == 18'd0) ? 18'sd1 : $signed(w_ref_new);
                            err_power <= w_err_new;
                            mer_valid <= 1'b1;
                            r_cnt     <= '0;
                            r_abs_acc <= '0;
                            r_err_acc <= '0;
                        end else begin
                            r_cnt     <= r_cnt + 1'b1;
                            r_abs_acc <= w_abs_sum;
                            r_err_acc <= w_err_sum;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ask4_slicer_mer.sv
// Bench for ask4_slicer_mer: three parameterisations share one stimulus stream,
// a behavioural model queues expected outputs per symbol enable.
module tb_ask4_slicer_mer;

    typedef struct packed {
        logic [2:0][1:0]  sym;
        logic [2:0][17:0] dec;
        logic [2:0][17:0] rf;
        logic [2:0][20:0] er;
        logic [2:0]       mv;
    } exp_t;

    logic               clk;
    logic               reset;
    logic               sam_clk_en;
    logic               sym_clk_en;
    logic               clear;
    logic signed [17:0] x_in;

    logic [1:0]         w_sym [3];
    logic signed [17:0] w_dec [3];
    logic signed [17:0] w_ref [3];
    logic [20:0]        w_err [3];
    logic               w_mv  [3];

    int n_err;
    int n_chk;
    exp_t q[$];

    int     P_L [3] = '{10, 2, 2};
    int     P_S [3] = '{32, 0, 3};
    int     m_ref [3];
    int     m_err [3];
    bit     m_acc [3];
    int     m_sk  [3];
    int     m_cnt [3];
    longint m_sa  [3];
    longint m_se  [3];

    ask4_slicer_mer #(.LOG2_N(10), .SKIP_SYMS(32), .REF_INIT(16384)) u_def (
        .clk(clk), .reset(reset), .sam_clk_en(sam_clk_en), .sym_clk_en(sym_clk_en),
        .x_in(x_in), .clear(clear), .sym_out(w_sym[0]), .dec_level(w_dec[0]),
        .ref_level(w_ref[0]), .err_power(w_err[0]), .mer_valid(w_mv[0]));

    ask4_slicer_mer #(.LOG2_N(2), .SKIP_SYMS(0), .REF_INIT(16384)) u_n2 (
        .clk(clk), .reset(reset), .sam_clk_en(sam_clk_en), .sym_clk_en(sym_clk_en),
        .x_in(x_in), .clear(clear), .sym_out(w_sym[1]), .dec_level(w_dec[1]),
        .ref_level(w_ref[1]), .err_power(w_err[1]), .mer_valid(w_mv[1]));

    ask4_slicer_mer #(.LOG2_N(2), .SKIP_SYMS(3), .REF_INIT(16384)) u_sk (
        .clk(clk), .reset(reset), .sam_clk_en(sam_clk_en), .sym_clk_en(sym_clk_en),
        .x_in(x_in), .clear(clear), .sym_out(w_sym[2]), .dec_level(w_dec[2]),
        .ref_level(w_ref[2]), .err_power(w_err[2]), .mer_valid(w_mv[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void slice_ref(input int x, input int a, output int sym, output int lvl,
                                      output int dec, output int sqs, output int ab);
        longint e;
        if (x < -2 * a) begin
            sym = 0; lvl = -3 * a;
        end else if (x < 0) begin
            sym = 1; lvl = -a;
        end else if (x < 2 * a) begin
            sym = 2; lvl = a;
        end else begin
            sym = 3; lvl = 3 * a;
        end
        dec = (lvl > 131071) ? 131071 : ((lvl < -131071) ? -131071 : lvl);
        e   = longint'(x - lvl);
        sqs = int'((e * e) >> 17);
        ab  = (x < 0) ? -x : x;
        if (ab > 131071) ab = 131071;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_ref[k] = 16384; m_err[k] = 0; m_acc[k] = (P_S[k] == 0);
            m_sk[k] = 0; m_cnt[k] = 0; m_sa[k] = 0; m_se[k] = 0;
        end
        q.delete();
    endtask

    task automatic model_step(input int v, input bit c);
        exp_t ex;
        int sym, lvl, dec, sqs, ab;
        longint r;
        for (int k = 0; k < 3; k++) begin
            slice_ref(v, m_ref[k], sym, lvl, dec, sqs, ab);
            ex.sym[k] = 2'(sym);
            ex.dec[k] = 18'(dec);
            ex.mv[k]  = 1'b0;
            if (c) begin
                m_acc[k] = (P_S[k] == 0); m_sk[k] = 0; m_cnt[k] = 0; m_sa[k] = 0; m_se[k] = 0;
            end else if (!m_acc[k]) begin
                if (m_sk[k] == P_S[k] - 1) begin
                    m_acc[k] = 1'b1; m_sk[k] = 0;
                end else begin
                    m_sk[k]++;
                end
            end else begin
                m_sa[k] += ab;
                m_se[k] += sqs;
                if (m_cnt[k] == (1 << P_L[k]) - 1) begin
                    r = m_sa[k] >> (P_L[k] + 1);
                    m_ref[k] = (r == 0) ? 1 : int'(r);
                    m_err[k] = int'(m_se[k] >> P_L[k]);
                    ex.mv[k] = 1'b1;
                    m_sa[k] = 0; m_se[k] = 0; m_cnt[k] = 0;
                end else begin
                    m_cnt[k]++;
                end
            end
            ex.rf[k] = 18'(m_ref[k]);
            ex.er[k] = 21'(m_err[k]);
        end
        q.push_back(ex);
    endtask

    task automatic do_reset();
        reset = 1'b0; sym_clk_en = 1'b0; clear = 1'b0; x_in = '0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
    endtask

    // Three idle clocks then a one-clock symbol enable; outputs are sampled 1 ns after the edge.
    task automatic drive_sym(input int v, input bit c);
        repeat (3) @(posedge clk);
        #1;
        x_in = 18'(v); sym_clk_en = 1'b1; clear = c;
        model_step(v, c);
        @(posedge clk);
        #1;
        sym_clk_en = 1'b0; clear = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            n_chk += 5;
            if (w_sym[k] !== 2'b00) begin n_err++; $display("FAIL reset sym u%0d: got %0d want 0", k, w_sym[k]); end
            if (w_dec[k] !== 18'sd0) begin n_err++; $display("FAIL reset dec u%0d: got %0d want 0", k, w_dec[k]); end
            if (w_ref[k] !== 18'sd16384) begin n_err++; $display("FAIL reset ref u%0d: got %0d want 16384", k, w_ref[k]); end
            if (w_err[k] !== 21'd0) begin n_err++; $display("FAIL reset err u%0d: got %0d want 0", k, w_err[k]); end
            if (w_mv[k] !== 1'b0) begin n_err++; $display("FAIL reset mv u%0d: got %0d want 0", k, w_mv[k]); end
        end
    endtask

    task automatic test_slicer_const();
        int vals [10] = '{20000, 20000, 20000, 20000, -32768, 32767, 32768, -32769, 0, -1};
        exp_t ex;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive_sym(vals[i], 1'b0);
            ex = q.pop_front();
            for (int k = 0; k < 3; k++) begin
                n_chk += 5;
                if (w_sym[k] !== ex.sym[k]) begin n_err++; $display("FAIL const sym u%0d n%0d: got %0d want %0d", k, i, w_sym[k], ex.sym[k]); end
                if (w_dec[k] !== ex.dec[k]) begin n_err++; $display("FAIL const dec u%0d n%0d: got %0d want %0d", k, i, w_dec[k], $signed(ex.dec[k])); end
                if (w_ref[k] !== ex.rf[k]) begin n_err++; $display("FAIL const ref u%0d n%0d: got %0d want %0d", k, i, w_ref[k], ex.rf[k]); end
                if (w_err[k] !== ex.er[k]) begin n_err++; $display("FAIL const err u%0d n%0d: got %0d want %0d", k, i, w_err[k], ex.er[k]); end
                if (w_mv[k] !== ex.mv[k]) begin n_err++; $display("FAIL const mv u%0d n%0d: got %0d want %0d", k, i, w_mv[k], ex.mv[k]); end
            end
        end
    endtask

    task automatic test_levels();
        int base [4] = '{-49152, -16384, 16384, 49152};
        int want_err [3] = '{0, 8, 51200};
        int want_ref [3] = '{16384, 16384, 65535};
        int v;
        exp_t ex;
        for (int p = 0; p < 3; p++) begin
            do_reset();
            for (int i = 0; i < 12; i++) begin
                v = (p == 2) ? -131072 : base[i % 4] + ((p == 1) ? 1024 : 0);
                drive_sym(v, 1'b0);
                ex = q.pop_front();
                for (int k = 0; k < 3; k++) begin
                    n_chk += 5;
                    if (w_sym[k] !== ex.sym[k]) begin n_err++; $display("FAIL levels sym p%0d u%0d n%0d: got %0d want %0d", p, k, i, w_sym[k], ex.sym[k]); end
                    if (w_dec[k] !== ex.dec[k]) begin n_err++; $display("FAIL levels dec p%0d u%0d n%0d: got %0d want %0d", p, k, i, w_dec[k], $signed(ex.dec[k])); end
                    if (w_ref[k] !== ex.rf[k]) begin n_err++; $display("FAIL levels ref p%0d u%0d n%0d: got %0d want %0d", p, k, i, w_ref[k], ex.rf[k]); end
                    if (w_err[k] !== ex.er[k]) begin n_err++; $display("FAIL levels err p%0d u%0d n%0d: got %0d want %0d", p, k, i, w_err[k], ex.er[k]); end
                    if (w_mv[k] !== ex.mv[k]) begin n_err++; $display("FAIL levels mv p%0d u%0d n%0d: got %0d want %0d", p, k, i, w_mv[k], ex.mv[k]); end
                end
                if (i == 3) begin
                    n_chk += 3;
                    if (w_mv[1] !== 1'b1) begin n_err++; $display("FAIL levels blk_mv p%0d: got %0d want 1", p, w_mv[1]); end
                    if (w_err[1] !== 21'(want_err[p])) begin n_err++; $display("FAIL levels blk_err p%0d: got %0d want %0d", p, w_err[1], want_err[p]); end
                    if (w_ref[1] !== 18'(want_ref[p])) begin n_err++; $display("FAIL levels blk_ref p%0d: got %0d want %0d", p, w_ref[1], want_ref[p]); end
                end
            end
        end
    endtask

    task automatic test_skip();
        int base [4] = '{-49152, -16384, 16384, 49152};
        int v;
        int first_mv;
        exp_t ex;
        do_reset();
        first_mv = -1;
        for (int i = 0; i < 11; i++) begin
            v = (i < 3) ? 131071 : base[(i - 3) % 4];
            drive_sym(v, 1'b0);
            ex = q.pop_front();
            if (w_mv[2] === 1'b1 && first_mv < 0) first_mv = i + 1;
            for (int k = 0; k < 3; k++) begin
                n_chk += 5;
                if (w_sym[k] !== ex.sym[k]) begin n_err++; $display("FAIL skip sym u%0d n%0d: got %0d want %0d", k, i, w_sym[k], ex.sym[k]); end
                if (w_dec[k] !== ex.dec[k]) begin n_err++; $display("FAIL skip dec u%0d n%0d: got %0d want %0d", k, i, w_dec[k], $signed(ex.dec[k])); end
                if (w_ref[k] !== ex.rf[k]) begin n_err++; $display("FAIL skip ref u%0d n%0d: got %0d want %0d", k, i, w_ref[k], ex.rf[k]); end
                if (w_err[k] !== ex.er[k]) begin n_err++; $display("FAIL skip err u%0d n%0d: got %0d want %0d", k, i, w_err[k], ex.er[k]); end
                if (w_mv[k] !== ex.mv[k]) begin n_err++; $display("FAIL skip mv u%0d n%0d: got %0d want %0d", k, i, w_mv[k], ex.mv[k]); end
            end
        end
        n_chk += 2;
        if (first_mv != 7) begin n_err++; $display("FAIL skip first_mv: got enable %0d want 7", first_mv); end
        if (w_err[2] !== 21'd0) begin n_err++; $display("FAIL skip err_sk: got %0d want 0", w_err[2]); end
    endtask

    task automatic test_clear();
        int base [4] = '{-49152, -16384, 16384, 49152};
        exp_t ex;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive_sym(base[i % 4] + 512, (i == 5));
            ex = q.pop_front();
            for (int k = 0; k < 3; k++) begin
                n_chk += 5;
                if (w_sym[k] !== ex.sym[k]) begin n_err++; $display("FAIL clear sym u%0d n%0d: got %0d want %0d", k, i, w_sym[k], ex.sym[k]); end
                if (w_dec[k] !== ex.dec[k]) begin n_err++; $display("FAIL clear dec u%0d n%0d: got %0d want %0d", k, i, w_dec[k], $signed(ex.dec[k])); end
                if (w_ref[k] !== ex.rf[k]) begin n_err++; $display("FAIL clear ref u%0d n%0d: got %0d want %0d", k, i, w_ref[k], ex.rf[k]); end
                if (w_err[k] !== ex.er[k]) begin n_err++; $display("FAIL clear err u%0d n%0d: got %0d want %0d", k, i, w_err[k], ex.er[k]); end
                if (w_mv[k] !== ex.mv[k]) begin n_err++; $display("FAIL clear mv u%0d n%0d: got %0d want %0d", k, i, w_mv[k], ex.mv[k]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int base [4] = '{-49152, -16384, 16384, 49152};
        exp_t ex;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive_sym(base[i % 4] + 2048, 1'b0);
            void'(q.pop_front());
        end
        do_reset();
        for (int k = 0; k < 3; k++) begin
            n_chk += 4;
            if (w_sym[k] !== 2'b00) begin n_err++; $display("FAIL rstmid sym u%0d: got %0d want 0", k, w_sym[k]); end
            if (w_dec[k] !== 18'sd0) begin n_err++; $display("FAIL rstmid dec u%0d: got %0d want 0", k, w_dec[k]); end
            if (w_ref[k] !== 18'sd16384) begin n_err++; $display("FAIL rstmid ref u%0d: got %0d want 16384", k, w_ref[k]); end
            if (w_err[k] !== 21'd0) begin n_err++; $display("FAIL rstmid err u%0d: got %0d want 0", k, w_err[k]); end
        end
        for (int i = 0; i < 8; i++) begin
            drive_sym(base[(i + 1) % 4], 1'b0);
            ex = q.pop_front();
            for (int k = 0; k < 3; k++) begin
                n_chk += 5;
                if (w_sym[k] !== ex.sym[k]) begin n_err++; $display("FAIL rstmid sym u%0d n%0d: got %0d want %0d", k, i, w_sym[k], ex.sym[k]); end
                if (w_dec[k] !== ex.dec[k]) begin n_err++; $display("FAIL rstmid dec u%0d n%0d: got %0d want %0d", k, i, w_dec[k], $signed(ex.dec[k])); end
                if (w_ref[k] !== ex.rf[k]) begin n_err++; $display("FAIL rstmid ref u%0d n%0d: got %0d want %0d", k, i, w_ref[k], ex.rf[k]); end
                if (w_err[k] !== ex.er[k]) begin n_err++; $display("FAIL rstmid err u%0d n%0d: got %0d want %0d", k, i, w_err[k], ex.er[k]); end
                if (w_mv[k] !== ex.mv[k]) begin n_err++; $display("FAIL rstmid mv u%0d n%0d: got %0d want %0d", k, i, w_mv[k], ex.mv[k]); end
            end
        end
    endtask

    initial begin
        n_err = 0;
        n_chk = 0;
        sam_clk_en = 1'b0;
        sym_clk_en = 1'b0;
        clear = 1'b0;
        reset = 1'b0;
        x_in = '0;
        test_reset();
        test_slicer_const();
        test_levels();
        test_skip();
        test_clear();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
